konark_eoc_unit: RTL and testbench
==================================

KONARK_EOC_UNIT -- requirements
Module: konark_eoc_unit

Interface
REQ-001 SHALL have parameter AddrWidth, default 48, request address width.
REQ-002 SHALL have parameter DataWidth, default 64, request data width (64 only).
REQ-003 SHALL have parameter TohostAddr, default 48'h0000_0100_0000, byte address of tohost register.
REQ-004 SHALL have parameter FromhostAddr, default 48'h0000_0100_0008, byte address of fromhost register.
REQ-005 SHALL have parameter WdogCycles, default 32'd1_000_000, watchdog limit in cycles.
REQ-006 SHALL have one clock, clk_i, and an asynchronous active-high reset, rst_i; SHALL sample all inputs on rising clk_i.
REQ-007 Ports (name direction width meaning): clk_i in 1 clock; rst_i in 1 async active-high reset.
REQ-008 req_valid_i in 1 / req_ready_o out 1 / req_addr_i in AddrWidth / req_write_i in 1 / req_wdata_i in 64: core request channel.
REQ-009 rsp_valid_o out 1 / rsp_rdata_o out 64: single-beat response channel, no backpressure.
REQ-010 host_req_o out 1 / host_payload_o out 64 / host_ack_i in 1 / host_data_i in 64: syscall handoff to harness.
REQ-011 eoc_o out 1 end-of-computation; exit_code_o out 32 program exit code; timeout_o out 1 watchdog fired.

Function
REQ-012 FSM states: IDLE, RESP, HOST_WAIT, DONE.
REQ-013 IDLE: req_ready_o=1; a handshake (req_valid_i & req_ready_o) moves to RESP, except a tohost write with wdata[0]=0, which moves to HOST_WAIT.
REQ-014 RESP: rsp_valid_o=1 exactly one cycle, then IDLE; request-to-response latency exactly 1 cycle.
REQ-015 Reads: tohost returns tohost register; fromhost returns fromhost register; any other address returns 0.
REQ-016 Write to FromhostAddr stores wdata; writes to unmapped addresses are acknowledged and discarded.
REQ-017 Tohost write with wdata[0]=1: tohost register updated, eoc_o=1 and exit_code_o=wdata[32:1] from the next cycle; FSM enters DONE after RESP.
REQ-018 Tohost write with wdata[0]=0: host_req_o=1 and host_payload_o=wdata held until host_ack_i=1; response withheld.
REQ-019 HOST_WAIT on host_ack_i=1: fromhost<=host_data_i, tohost<=0, host_req_o drops the same edge, go to RESP.
REQ-020 host_ack_i outside HOST_WAIT SHALL be ignored.
REQ-021 DONE: req_ready_o=0; eoc_o, exit_code_o and timeout_o hold until reset.
REQ-022 req_ready_o SHALL be 0 in RESP and HOST_WAIT; no request is buffered.

Reset
REQ-023 On rst_i: state IDLE; tohost=0, fromhost=0; req_ready_o=0 during reset, 1 from the first cycle after release; rsp_valid_o, host_req_o, eoc_o, timeout_o=0; exit_code_o=0; host_payload_o=0; rsp_rdata_o=0.
REQ-024 Reset asserted mid-operation (incl. HOST_WAIT) SHALL abandon the operation with no response issued.

Configuration
REQ-025 KONARK_EOC_WATCHDOG_EN defined: 32-bit cycle counter runs from reset release until eoc_o; on reaching WdogCycles it sets timeout_o=1, eoc_o=1 and exit_code_o=32'hFFFF_FFFF, and enters DONE; a pending host request is dropped.
REQ-026 KONARK_EOC_WATCHDOG_EN undefined: no counter; timeout_o tied 0.
REQ-027 Watchdog limit reached in the same cycle as a tohost exit write: the write wins, timeout_o stays 0.

Structure
REQ-028 konark_eoc_pkg SHALL hold the FSM state enum, default TohostAddr/FromhostAddr, and exit-code constant for timeout.
REQ-029 Sub-module konark_eoc_wdog SHALL implement the watchdog counter; it is instantiated only under the macro.

Verification
REQ-030 Write tohost=64'h1 -> rsp after 1 cycle, eoc_o=1, exit_code_o=0, req_ready_o=0 thereafter.
REQ-031 Write tohost=64'h7 -> eoc_o=1, exit_code_o=3.
REQ-032 Write tohost=64'h8000_1000 -> host_req_o=1, payload=64'h8000_1000; ack after 10 cycles with host_data_i=64'h2A -> rsp next cycle, read fromhost returns 64'h2A, read tohost returns 0.
REQ-033 Read 48'h0 and write 48'h10 -> rsp_rdata_o=0, registers unchanged.
REQ-034 Assert rst_i during HOST_WAIT -> no rsp, host_req_o=0, IDLE after release.
REQ-035 Macro on, WdogCycles=100, no traffic -> at cycle 100 timeout_o=1, eoc_o=1, exit_code_o=32'hFFFF_FFFF.

Source files
------------

// File: rtl/konark_eoc_pkg.sv
// konark_eoc_pkg: shared types and constants for the end-of-computation unit.
package konark_eoc_pkg;

  // Controller states: accept requests, answer them, wait on the harness, or halt.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESP      = 2'd1,
    HOST_WAIT = 2'd2,
    DONE      = 2'd3
  } eoc_state_e;

  // Default mailbox locations in the core's byte address space.
  localparam logic [47:0] DEF_TOHOST_ADDR   = 48'h0000_0100_0000;
  localparam logic [47:0] DEF_FROMHOST_ADDR = 48'h0000_0100_0008;

  // Exit code reported when the watchdog ends the run.
  localparam logic [31:0] TIMEOUT_EXIT_CODE = 32'hFFFF_FFFF;

  // A tohost write with bit 0 set carries the exit code in bits 32:1.
  function automatic logic [31:0] exitCodeOf(input logic [63:0] wdata);
    return wdata[32:1];
  endfunction

endpackage

// File: rtl/konark_eoc_wdog.sv
// konark_eoc_wdog: free-running cycle counter that flags when a run takes too long.
module konark_eoc_wdog #(
  parameter logic [31:0] Limit = 32'd1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic fire_o
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Count cycles while the run is live, saturating at the limit.
  always_comb begin
    count_d = count_q;
    if (run_i && (count_q != Limit)) begin
      count_d = count_q + 32'd1;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fire on the edge that completes the Limit-th counted cycle.
  assign fire_o = run_i && ((count_q + 32'd1) == Limit);

endmodule

// File: rtl/konark_eoc_unit.sv
// konark_eoc_unit: tohost/fromhost mailbox that detects program exit and hands
// syscalls to the harness. Define KONARK_EOC_WATCHDOG_EN to build in a watchdog
// that ends runaway programs with exit code 0xFFFF_FFFF.
module konark_eoc_unit
  import konark_eoc_pkg::*;
#(
  parameter int unsigned           AddrWidth    = 48,
  parameter int unsigned           DataWidth    = 64,
  parameter logic [AddrWidth-1:0]  TohostAddr   = AddrWidth'(DEF_TOHOST_ADDR),
  parameter logic [AddrWidth-1:0]  FromhostAddr = AddrWidth'(DEF_FROMHOST_ADDR),
  parameter logic [31:0]           WdogCycles   = 32'd1_000_000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 host_req_o,
  output logic [DataWidth-1:0] host_payload_o,
  input  logic                 host_ack_i,
  input  logic [DataWidth-1:0] host_data_i,
  output logic                 eoc_o,
  output logic [31:0]          exit_code_o,
  output logic                 timeout_o
);

  eoc_state_e           state_q,    state_d;
  logic [DataWidth-1:0] tohost_q,   tohost_d;
  logic [DataWidth-1:0] fromhost_q, fromhost_d;
  logic [DataWidth-1:0] rdata_q,    rdata_d;
  logic [DataWidth-1:0] payload_q,  payload_d;
  logic                 eoc_q,      eoc_d;
  logic [31:0]          exitCode_q, exitCode_d;
  logic                 timeout_q,  timeout_d;
  logic                 wdogFire;

`ifdef KONARK_EOC_WATCHDOG_EN
  konark_eoc_wdog #(
    .Limit (WdogCycles)
  ) u_wdog (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .run_i  (~eoc_q),
    .fire_o (wdogFire)
  );
`else
  // Without the watchdog the limit has no consumer and the run never times out.
  logic [31:0] unusedWdogCycles;
  assign unusedWdogCycles = WdogCycles;
  assign wdogFire         = 1'b0;
`endif

  // Next-state logic: decode requests, update mailbox registers, track exit/timeout.
  always_comb begin
    state_d    = state_q;
    tohost_d   = tohost_q;
    fromhost_d = fromhost_q;
    rdata_d    = rdata_q;
    payload_d  = payload_q;
    eoc_d      = eoc_q;
    exitCode_d = exitCode_q;
    timeout_d  = timeout_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = RESP;
          rdata_d = '0;
          if (!req_write_i) begin
            if (req_addr_i == TohostAddr) begin
              rdata_d = tohost_q;
            end else if (req_addr_i == FromhostAddr) begin
              rdata_d = fromhost_q;
            end
          end else if (req_addr_i == TohostAddr) begin
            tohost_d = req_wdata_i;
            if (req_wdata_i[0]) begin
              eoc_d      = 1'b1;
              exitCode_d = exitCodeOf(req_wdata_i);
            end else begin
              payload_d = req_wdata_i;
              state_d   = HOST_WAIT;
            end
          end else if (req_addr_i == FromhostAddr) begin
            fromhost_d = req_wdata_i;
          end
        end
      end
      RESP: begin
        state_d = eoc_q ? DONE : IDLE;
      end
      HOST_WAIT: begin
        if (host_ack_i) begin
          fromhost_d = host_data_i;
          tohost_d   = '0;
          rdata_d    = '0;
          state_d    = RESP;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A timeout only lands if no exit write claimed this same edge.
    if (wdogFire && !eoc_d) begin
      timeout_d  = 1'b1;
      eoc_d      = 1'b1;
      exitCode_d = TIMEOUT_EXIT_CODE;
      state_d    = DONE;
    end
  end

  // State and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      tohost_q   <= '0;
      fromhost_q <= '0;
      rdata_q    <= '0;
      payload_q  <= '0;
      eoc_q      <= 1'b0;
      exitCode_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tohost_q   <= tohost_d;
      fromhost_q <= fromhost_d;
      rdata_q    <= rdata_d;
      payload_q  <= payload_d;
      eoc_q      <= eoc_d;
      exitCode_q <= exitCode_d;
      timeout_q  <= timeout_d;
    end
  end

  // Ready is masked by reset so the core sees 0 while reset is held.
  assign req_ready_o    = (state_q == IDLE) && !rst_i;
  assign rsp_valid_o    = (state_q == RESP);
  assign rsp_rdata_o    = (state_q == RESP) ? rdata_q : '0;
  assign host_req_o     = (state_q == HOST_WAIT);
  assign host_payload_o = (state_q == HOST_WAIT) ? payload_q : '0;
  assign eoc_o          = eoc_q;
  assign exit_code_o    = exitCode_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_konark_eoc_unit.sv
// tb_konark_eoc_unit: directed, table-driven bench for the end-of-computation unit.
// Define KONARK_EOC_WATCHDOG_EN for both RTL and bench to exercise the watchdog.
module tb_konark_eoc_unit;

  localparam logic [47:0] TOHOST   = 48'h0000_0100_0000;
  localparam logic [47:0] FROMHOST = 48'h0000_0100_0008;
`ifdef KONARK_EOC_WATCHDOG_EN
  localparam logic [31:0] WDOG = 32'd100;
`else
  localparam logic [31:0] WDOG = 32'd1_000_000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [47:0] reqAddr = '0;
  logic        reqWrite = 1'b0;
  logic [63:0] reqWdata = '0;
  logic        rspValid;
  logic [63:0] rspRdata;
  logic        hostReq;
  logic [63:0] hostPayload;
  logic        hostAck = 1'b0;
  logic [63:0] hostData = '0;
  logic        eoc;
  logic [31:0] exitCode;
  logic        timeout;

  int checkCount = 0;
  int failCount  = 0;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  konark_eoc_unit #(
    .AddrWidth    (48),
    .DataWidth    (64),
    .TohostAddr   (TOHOST),
    .FromhostAddr (FROMHOST),
    .WdogCycles   (WDOG)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (reqValid),
    .req_ready_o    (reqReady),
    .req_addr_i     (reqAddr),
    .req_write_i    (reqWrite),
    .req_wdata_i    (reqWdata),
    .rsp_valid_o    (rspValid),
    .rsp_rdata_o    (rspRdata),
    .host_req_o     (hostReq),
    .host_payload_o (hostPayload),
    .host_ack_i     (hostAck),
    .host_data_i    (hostData),
    .eoc_o          (eoc),
    .exit_code_o    (exitCode),
    .timeout_o      (timeout)
  );

  typedef struct {
    logic        write;
    logic [47:0] addr;
    logic [63:0] wdata;
    logic [63:0] expRdata;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Present one request for a single cycle; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic write, input logic [47:0] addr, input logic [63:0] wdata);
    @(negedge clk);
    reqValid = 1'b1;
    reqWrite = write;
    reqAddr  = addr;
    reqWdata = wdata;
    @(negedge clk);
    reqValid = 1'b0;
    reqWrite = 1'b0;
    reqAddr  = '0;
    reqWdata = '0;
  endtask

  // Pulse reset, checking the reset values; returns 1 ns after release at a negedge.
  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstReady",   {63'd0, reqReady},  64'd0);
    checkOutput("rstRspV",    {63'd0, rspValid},  64'd0);
    checkOutput("rstRdata",   rspRdata,           64'd0);
    checkOutput("rstHostReq", {63'd0, hostReq},   64'd0);
    checkOutput("rstPayload", hostPayload,        64'd0);
    checkOutput("rstEoc",     {63'd0, eoc},       64'd0);
    checkOutput("rstExit",    {32'd0, exitCode},  64'd0);
    checkOutput("rstTimeout", {63'd0, timeout},   64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("relReady", {63'd0, reqReady}, 64'd1);
  endtask

  // Exit write: response after one cycle, eoc/exit code set, unit then halts.
  task automatic exitSeq(input logic [63:0] wdata, input logic [31:0] expExit);
    resetDut();
    applyStimulus(1'b1, TOHOST, wdata);
    checkOutput("exitRspV",    {63'd0, rspValid}, 64'd1);
    checkOutput("exitEoc",     {63'd0, eoc},      64'd1);
    checkOutput("exitCode",    {32'd0, exitCode}, {32'd0, expExit});
    checkOutput("exitTimeout", {63'd0, timeout},  64'd0);
    @(negedge clk);
    checkOutput("doneRspV",  {63'd0, rspValid}, 64'd0);
    checkOutput("doneReady", {63'd0, reqReady}, 64'd0);
    applyStimulus(1'b0, FROMHOST, 64'd0);
    checkOutput("doneNoRsp", {63'd0, rspValid}, 64'd0);
    @(negedge clk);
    checkOutput("doneNoRsp2", {63'd0, rspValid}, 64'd0);
    checkOutput("doneEoc",    {63'd0, eoc},      64'd1);
    checkOutput("doneExit",   {32'd0, exitCode}, {32'd0, expExit});
  endtask

  initial begin
    vecs[0] = '{1'b0, TOHOST,        64'd0,                   64'd0};
    vecs[1] = '{1'b0, FROMHOST,      64'd0,                   64'd0};
    vecs[2] = '{1'b1, FROMHOST,      64'hDEAD_BEEF_0000_1234, 64'd0};
    vecs[3] = '{1'b0, FROMHOST,      64'd0,                   64'hDEAD_BEEF_0000_1234};
    vecs[4] = '{1'b0, 48'h0,         64'd0,                   64'd0};
    vecs[5] = '{1'b1, 48'h10,        64'h0123_4567_89AB_CDEF, 64'd0};
    vecs[6] = '{1'b0, FROMHOST,      64'd0,                   64'hDEAD_BEEF_0000_1234};
    vecs[7] = '{1'b0, TOHOST,        64'd0,                   64'd0};
    vecs[8] = '{1'b1, FROMHOST,      64'h0000_0000_0000_0055, 64'd0};
    vecs[9] = '{1'b0, 48'h10,        64'd0,                   64'd0};

    // Table: single-beat reads and writes of mapped and unmapped addresses.
    resetDut();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].write, vecs[i].addr, vecs[i].wdata);
      checkOutput($sformatf("vec%0d_rspV", i),  {63'd0, rspValid}, 64'd1);
      checkOutput($sformatf("vec%0d_rdata", i), rspRdata,          vecs[i].expRdata);
      checkOutput($sformatf("vec%0d_busy", i),  {63'd0, reqReady}, 64'd0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_rspDrop", i), {63'd0, rspValid}, 64'd0);
      checkOutput($sformatf("vec%0d_ready", i),   {63'd0, reqReady}, 64'd1);
    end

    // Syscall handoff, with a stray ack beforehand that must be ignored.
    resetDut();
    @(negedge clk);
    hostAck  = 1'b1;
    hostData = 64'h99;
    @(negedge clk);
    hostAck  = 1'b0;
    hostData = '0;
    checkOutput("strayAckRspV", {63'd0, rspValid}, 64'd0);
    applyStimulus(1'b0, FROMHOST, 64'd0);
    checkOutput("strayAckFromhost", rspRdata, 64'd0);
    @(negedge clk);
    applyStimulus(1'b1, TOHOST, 64'h8000_1000);
    checkOutput("sysHostReq", {63'd0, hostReq}, 64'd1);
    checkOutput("sysPayload", hostPayload,      64'h8000_1000);
    checkOutput("sysRspV",    {63'd0, rspValid}, 64'd0);
    checkOutput("sysReady",   {63'd0, reqReady}, 64'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("sysWait%0d_req", k), {63'd0, hostReq},  64'd1);
      checkOutput($sformatf("sysWait%0d_rsp", k), {63'd0, rspValid}, 64'd0);
    end
    hostAck  = 1'b1;
    hostData = 64'h2A;
    @(negedge clk);
    hostAck  = 1'b0;
    hostData = '0;
    checkOutput("ackRspV",    {63'd0, rspValid}, 64'd1);
    checkOutput("ackHostReq", {63'd0, hostReq},  64'd0);
    checkOutput("ackEoc",     {63'd0, eoc},      64'd0);
    @(negedge clk);
    checkOutput("ackRspDrop", {63'd0, rspValid}, 64'd0);
    checkOutput("ackReady",   {63'd0, reqReady}, 64'd1);
    applyStimulus(1'b0, FROMHOST, 64'd0);
    checkOutput("sysFromhost", rspRdata, 64'h2A);
    @(negedge clk);
    applyStimulus(1'b0, TOHOST, 64'd0);
    checkOutput("sysTohost", rspRdata, 64'd0);
    @(negedge clk);

    // Reset while waiting on the harness abandons the syscall.
    resetDut();
    applyStimulus(1'b1, TOHOST, 64'h2);
    checkOutput("rwHostReq", {63'd0, hostReq}, 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("rwRstHostReq", {63'd0, hostReq},  64'd0);
    checkOutput("rwRstRspV",    {63'd0, rspValid}, 64'd0);
    checkOutput("rwRstReady",   {63'd0, reqReady}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rwRelReady", {63'd0, reqReady}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rwIdle%0d_rsp", k), {63'd0, rspValid}, 64'd0);
      checkOutput($sformatf("rwIdle%0d_req", k), {63'd0, hostReq},  64'd0);
    end
    applyStimulus(1'b0, TOHOST, 64'd0);
    checkOutput("rwTohost", rspRdata, 64'd0);

    // Program exits with assorted codes.
    exitSeq(64'h1, 32'd0);
    exitSeq(64'h7, 32'd3);
    exitSeq(64'h0000_0001_2345_6789, 32'h91A2_B3C4);

    // Long idle stretch: the watchdog fires on cycle 100 only when built in.
    resetDut();
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      if (k == 99) begin
        checkOutput("wd99Timeout", {63'd0, timeout}, 64'd0);
        checkOutput("wd99Eoc",     {63'd0, eoc},     64'd0);
      end
`ifdef KONARK_EOC_WATCHDOG_EN
      if (k == 100) begin
        checkOutput("wd100Timeout", {63'd0, timeout},  64'd1);
        checkOutput("wd100Eoc",     {63'd0, eoc},      64'd1);
        checkOutput("wd100Exit",    {32'd0, exitCode}, 64'h0000_0000_FFFF_FFFF);
        checkOutput("wd100Ready",   {63'd0, reqReady}, 64'd0);
      end
      if (k == 110) begin
        checkOutput("wdHoldTimeout", {63'd0, timeout},  64'd1);
        checkOutput("wdHoldExit",    {32'd0, exitCode}, 64'h0000_0000_FFFF_FFFF);
      end
`else
      if (k == 110) begin
        checkOutput("noWdTimeout", {63'd0, timeout}, 64'd0);
        checkOutput("noWdEoc",     {63'd0, eoc},     64'd0);
        checkOutput("noWdReady",   {63'd0, reqReady}, 64'd1);
      end
`endif
    end

`ifdef KONARK_EOC_WATCHDOG_EN
    // Timeout while a syscall is pending drops the host request.
    resetDut();
    repeat (89) @(negedge clk);
    applyStimulus(1'b1, TOHOST, 64'h4);
    repeat (8) @(negedge clk);
    checkOutput("wdSysPending", {63'd0, hostReq}, 64'd1);
    @(negedge clk);
    checkOutput("wdSysDropReq", {63'd0, hostReq},  64'd0);
    checkOutput("wdSysTimeout", {63'd0, timeout},  64'd1);
    checkOutput("wdSysRspV",    {63'd0, rspValid}, 64'd0);

    // Exit write accepted on the very edge the limit is reached wins.
    resetDut();
    repeat (99) @(negedge clk);
    reqValid = 1'b1;
    reqWrite = 1'b1;
    reqAddr  = TOHOST;
    reqWdata = 64'h7;
    @(negedge clk);
    reqValid = 1'b0;
    reqWrite = 1'b0;
    checkOutput("tieTimeout", {63'd0, timeout},  64'd0);
    checkOutput("tieEoc",     {63'd0, eoc},      64'd1);
    checkOutput("tieExit",    {32'd0, exitCode}, 64'd3);
    checkOutput("tieRspV",    {63'd0, rspValid}, 64'd1);
    @(negedge clk);
    checkOutput("tieTimeout2", {63'd0, timeout}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
